arm7tdmi_jtag_tap: RTL and testbench

ARM7TDMI_JTAG_TAP -- requirements
Module: arm7tdmi_jtag_tap

---
 rtl/arm7tdmi_jtag_tap.sv | 144 ++++++++++++++
 tb/tb_arm7tdmi_jtag_tap.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_jtag_tap.sv
// JTAG TAP controller for the ARM7TDMI debug port: 16-state TAP FSM, 4-bit IR,
// BYPASS and IDCODE data registers, plus selects and tdo muxing for the external ICE and SCAN_N chains.
module arm7tdmi_jtag_tap (
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       test_logic_reset,
  output logic       run_test_idle,
  output logic       select_dr_scan,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       exit1_dr,
  output logic       pause_dr,
  output logic       exit2_dr,
  output logic       update_dr,
  output logic       select_ir_scan,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       exit1_ir,
  output logic       pause_ir,
  output logic       exit2_ir,
  output logic       update_ir,
  output logic       bypass_select,
  output logic       idcode_select,
  output logic       ice_select,
  output logic       scan_n_select,
  input  logic       ice_tdo,
  input  logic       scan_n_tdo,
  output logic [3:0] current_ir
);

  localparam logic [31:0] IdcodeValue = 32'h3F0F0F0F;
  localparam logic [3:0]  IrIdcode    = 4'hE;
  localparam logic [3:0]  IrCapture   = 4'b0001;

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdateDr,
    StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdateIr
  } state_e;

  state_e      state_q;
  logic [3:0]  ir_q;
  logic [3:0]  ir_shift_q;
  logic        bypass_q;
  logic [31:0] idcode_q;

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q    <= StTlr;
      ir_q       <= IrIdcode;
      ir_shift_q <= IrCapture;
      bypass_q   <= 1'b0;
      idcode_q   <= IdcodeValue;
    end else begin
      unique case (state_q)
        StTlr: begin
          ir_q    <= IrIdcode;
          state_q <= tms ? StTlr : StRti;
        end
        StRti:   state_q <= tms ? StSelDr : StRti;
        StSelDr: state_q <= tms ? StSelIr : StCapDr;
        StCapDr: begin
          bypass_q <= 1'b0;
          if (idcode_select) idcode_q <= IdcodeValue;
          state_q <= tms ? StExit1Dr : StShiftDr;
        end
        StShiftDr: begin
          if (bypass_select) bypass_q <= tdi;
          idcode_q <= {tdi, idcode_q[31:1]};
          state_q  <= tms ? StExit1Dr : StShiftDr;
        end
        StExit1Dr:  state_q <= tms ? StUpdateDr : StPauseDr;
        StPauseDr:  state_q <= tms ? StExit2Dr : StPauseDr;
        StExit2Dr:  state_q <= tms ? StUpdateDr : StShiftDr;
        StUpdateDr: state_q <= tms ? StSelDr : StRti;
        StSelIr:    state_q <= tms ? StTlr : StCapIr;
        StCapIr: begin
          ir_shift_q <= IrCapture;
          state_q    <= tms ? StExit1Ir : StShiftIr;
        end
        StShiftIr: begin
          ir_shift_q <= {tdi, ir_shift_q[3:1]};
          state_q    <= tms ? StExit1Ir : StShiftIr;
        end
        StExit1Ir: state_q <= tms ? StUpdateIr : StPauseIr;
        StPauseIr: state_q <= tms ? StExit2Ir : StPauseIr;
        StExit2Ir: state_q <= tms ? StUpdateIr : StShiftIr;
        StUpdateIr: begin
          ir_q    <= ir_shift_q;
          state_q <= tms ? StSelDr : StRti;
        end
        default: state_q <= StTlr;
      endcase
    end
  end

  assign test_logic_reset = (state_q == StTlr);
  assign run_test_idle    = (state_q == StRti);
  assign select_dr_scan   = (state_q == StSelDr);
  assign capture_dr       = (state_q == StCapDr);
  assign shift_dr         = (state_q == StShiftDr);
  assign exit1_dr         = (state_q == StExit1Dr);
  assign pause_dr         = (state_q == StPauseDr);
  assign exit2_dr         = (state_q == StExit2Dr);
  assign update_dr        = (state_q == StUpdateDr);
  assign select_ir_scan   = (state_q == StSelIr);
  assign capture_ir       = (state_q == StCapIr);
  assign shift_ir         = (state_q == StShiftIr);
  assign exit1_ir         = (state_q == StExit1Ir);
  assign pause_ir         = (state_q == StPauseIr);
  assign exit2_ir         = (state_q == StExit2Ir);
  assign update_ir        = (state_q == StUpdateIr);

  assign current_ir = ir_q;

  // Unlisted opcodes fall back to BYPASS so exactly one select is always high.
  always_comb begin
    bypass_select = 1'b0;
    idcode_select = 1'b0;
    ice_select    = 1'b0;
    scan_n_select = 1'b0;
    case (ir_q)
      4'hE:       idcode_select = 1'b1;
      4'h2:       scan_n_select = 1'b1;
      4'hC, 4'h0: ice_select    = 1'b1;
      default:    bypass_select = 1'b1;
    endcase
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == StShiftIr) begin
      tdo = ir_shift_q[0];
    end else if (state_q == StShiftDr) begin
      if (idcode_select)      tdo = idcode_q[0];
      else if (ice_select)    tdo = ice_tdo;
      else if (scan_n_select) tdo = scan_n_tdo;
      else                    tdo = bypass_q;
    end
  end

endmodule

// File: tb/tb_arm7tdmi_jtag_tap.sv
// Directed bench for arm7tdmi_jtag_tap: reset, IR loads, IDCODE/BYPASS/SCAN_N/ICE shifting,
// five-tms recovery and trst during Shift-IR.
module tb_arm7tdmi_jtag_tap;

  logic       tck = 1'b0;
  logic       trst, tms, tdi, tdo;
  logic       ice_tdo, scan_n_tdo;
  logic       test_logic_reset, run_test_idle, select_dr_scan, capture_dr, shift_dr;
  logic       exit1_dr, pause_dr, exit2_dr, update_dr;
  logic       select_ir_scan, capture_ir, shift_ir, exit1_ir, pause_ir, exit2_ir, update_ir;
  logic       bypass_select, idcode_select, ice_select, scan_n_select;
  logic [3:0] current_ir;
  logic [15:0] flags;
  logic [3:0]  sels;

  int tests = 0;
  int fails = 0;

  always #5 tck = ~tck;

  arm7tdmi_jtag_tap dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo),
    .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
    .select_dr_scan(select_dr_scan), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .exit1_dr(exit1_dr), .pause_dr(pause_dr), .exit2_dr(exit2_dr), .update_dr(update_dr),
    .select_ir_scan(select_ir_scan), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .exit1_ir(exit1_ir), .pause_ir(pause_ir), .exit2_ir(exit2_ir), .update_ir(update_ir),
    .bypass_select(bypass_select), .idcode_select(idcode_select), .ice_select(ice_select),
    .scan_n_select(scan_n_select), .ice_tdo(ice_tdo), .scan_n_tdo(scan_n_tdo),
    .current_ir(current_ir)
  );

  assign flags = {test_logic_reset, run_test_idle, select_dr_scan, capture_dr, shift_dr,
                  exit1_dr, pause_dr, exit2_dr, update_dr, select_ir_scan, capture_ir,
                  shift_ir, exit1_ir, pause_ir, exit2_ir, update_ir};
  assign sels  = {bypass_select, idcode_select, ice_select, scan_n_select};

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: full 4-bit IR load, back to RTI.
  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_reset;
    trst = 1'b1;
    for (int i = 0; i < 5; i++) tick(0, 0);
    tests++;
    if (flags !== 16'h8000) begin
      $display("FAIL reset_flags got=%h exp=%h", flags, 16'h8000); fails++;
    end
    tests++;
    if (sels !== 4'b0100) begin
      $display("FAIL reset_selects got=%b exp=%b", sels, 4'b0100); fails++;
    end
    tests++;
    if (tdo !== 1'b0 || current_ir !== 4'hE) begin
      $display("FAIL reset_tdo_ir got tdo=%b ir=%h exp tdo=0 ir=e", tdo, current_ir); fails++;
    end
    trst = 1'b0;
    for (int i = 0; i < 6; i++) tick(1, 0);
    tick(0, 0);
    tests++;
    if (run_test_idle !== 1'b1 || current_ir !== 4'hE || flags !== 16'h4000) begin
      $display("FAIL reset_to_rti got flags=%h ir=%h exp flags=4000 ir=e", flags, current_ir);
      fails++;
    end
  endtask

  task automatic test_intest;
    tick(1, 0); tick(1, 0); tick(0, 0);
    tests++;
    if (capture_ir !== 1'b1) begin
      $display("FAIL intest_capture_ir got flags=%h exp capture_ir", flags); fails++;
    end
    tick(0, 0);
    tests++;
    if (shift_ir !== 1'b1 || tdo !== 1'b1) begin
      $display("FAIL intest_shift_ir got shift_ir=%b tdo=%b exp 1 1", shift_ir, tdo); fails++;
    end
    tick(0, 0); tick(0, 1); tick(1, 1);
    tests++;
    if (exit1_ir !== 1'b1 || tdo !== 1'b0) begin
      $display("FAIL intest_exit1_ir got exit1_ir=%b tdo=%b exp 1 0", exit1_ir, tdo); fails++;
    end
    tick(1, 0);
    tests++;
    if (update_ir !== 1'b1 || current_ir !== 4'hE) begin
      $display("FAIL intest_update got update_ir=%b ir=%h exp 1 e", update_ir, current_ir);
      fails++;
    end
    tick(0, 0);
    tests++;
    if (run_test_idle !== 1'b1 || current_ir !== 4'hC || sels !== 4'b0010) begin
      $display("FAIL intest_loaded got rti=%b ir=%h sels=%b exp 1 c 0010",
               run_test_idle, current_ir, sels);
      fails++;
    end
    // ICE chain drives tdo in Shift-DR.
    tick(1, 0); tick(0, 0); tick(0, 0);
    scan_n_tdo = 1'b0; ice_tdo = 1'b1; #1;
    tests++;
    if (tdo !== 1'b1) begin
      $display("FAIL ice_tdo_high got=%b exp=1", tdo); fails++;
    end
    ice_tdo = 1'b0; scan_n_tdo = 1'b1; #1;
    tests++;
    if (tdo !== 1'b0) begin
      $display("FAIL ice_tdo_low got=%b exp=0", tdo); fails++;
    end
    scan_n_tdo = 1'b0;
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  task automatic test_idcode;
    logic [31:0] got;
    got = '0;
    load_ir(4'hE);
    tick(1, 0); tick(0, 0);
    tests++;
    if (capture_dr !== 1'b1 || tdo !== 1'b0) begin
      $display("FAIL idcode_capture got capture_dr=%b tdo=%b exp 1 0", capture_dr, tdo); fails++;
    end
    tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo;
      tick(i == 31, 0);
    end
    tests++;
    if (got !== 32'h3F0F0F0F) begin
      $display("FAIL idcode_shift got=%h exp=%h", got, 32'h3F0F0F0F); fails++;
    end
    tick(0, 0);
    tests++;
    if (pause_dr !== 1'b1 || tdo !== 1'b0) begin
      $display("FAIL idcode_pause got pause_dr=%b tdo=%b exp 1 0", pause_dr, tdo); fails++;
    end
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  task automatic test_bypass;
    logic [2:0] pat;
    logic [2:0] exp;
    pat = 3'b101;
    exp = 3'b010;
    load_ir(4'hF);
    tests++;
    if (current_ir !== 4'hF || sels !== 4'b1000) begin
      $display("FAIL bypass_load got ir=%h sels=%b exp f 1000", current_ir, sels); fails++;
    end
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tdo !== exp[i]) begin
        $display("FAIL bypass_bit%0d got=%b exp=%b", i, tdo, exp[i]); fails++;
      end
      tick(0, pat[i]);
    end
    tests++;
    if (tdo !== 1'b1) begin
      $display("FAIL bypass_last got=%b exp=1", tdo); fails++;
    end
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  task automatic test_scan_n;
    load_ir(4'h2);
    tests++;
    if (current_ir !== 4'h2 || sels !== 4'b0001) begin
      $display("FAIL scan_n_load got ir=%h sels=%b exp 2 0001", current_ir, sels); fails++;
    end
    tick(1, 0); tick(0, 0); tick(0, 0);
    ice_tdo = 1'b0; scan_n_tdo = 1'b1; #1;
    tests++;
    if (tdo !== 1'b1) begin
      $display("FAIL scan_n_tdo_high got=%b exp=1", tdo); fails++;
    end
    ice_tdo = 1'b1; scan_n_tdo = 1'b0; #1;
    tests++;
    if (tdo !== 1'b0) begin
      $display("FAIL scan_n_tdo_low got=%b exp=0", tdo); fails++;
    end
    ice_tdo = 1'b0;
    tick(1, 0); tick(1, 0); tick(0, 0);
    load_ir(4'h5);
    tests++;
    if (current_ir !== 4'h5 || sels !== 4'b1000) begin
      $display("FAIL code5_bypass got ir=%h sels=%b exp 5 1000", current_ir, sels); fails++;
    end
  endtask

  task automatic test_tlr_five;
    load_ir(4'hF);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0);
    tests++;
    if (flags !== 16'h8000 || current_ir !== 4'hF) begin
      $display("FAIL five_tms got flags=%h ir=%h exp 8000 f", flags, current_ir); fails++;
    end
    tick(1, 0);
    tests++;
    if (current_ir !== 4'hE || idcode_select !== 1'b1) begin
      $display("FAIL tlr_forces_idcode got ir=%h idsel=%b exp e 1", current_ir, idcode_select);
      fails++;
    end
    tick(0, 0);
  endtask

  task automatic test_trst_mid_shift;
    load_ir(4'hF);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    trst = 1'b1;
    tick(0, 1);
    tests++;
    if (flags !== 16'h8000 || current_ir !== 4'hE || tdo !== 1'b0) begin
      $display("FAIL trst_mid_shift got flags=%h ir=%h tdo=%b exp 8000 e 0",
               flags, current_ir, tdo);
      fails++;
    end
    trst = 1'b0;
    tick(0, 0);
    tests++;
    if (run_test_idle !== 1'b1) begin
      $display("FAIL trst_release got flags=%h exp 4000", flags); fails++;
    end
  endtask

  initial begin
    trst = 1'b1; tms = 1'b0; tdi = 1'b0; ice_tdo = 1'b0; scan_n_tdo = 1'b0;
    test_reset();
    test_intest();
    test_idcode();
    test_bypass();
    test_scan_n();
    test_tlr_five();
    test_trst_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
